// File: rtl/sti_cmd_sched_pkg.sv
// Shared types and constants for the STI command scheduler: descriptor layout,
// length codes, issue FSM states and sizing.
package sti_cmd_sched_pkg;

  localparam int DESC_W     = 22;
  localparam int DATA_W     = 16;
  localparam int LEN_LSB    = 16;
  localparam int FILL_BIT   = 18;
  localparam int MSB_BIT    = 19;
  localparam int LOW_BIT    = 20;
  localparam int LAST_BIT   = 21;

  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = 3;
  localparam int GAP_CYCLES = 3;

  localparam logic [1:0] LEN_8  = 2'b00;
  localparam logic [1:0] LEN_16 = 2'b01;
  localparam logic [1:0] LEN_24 = 2'b10;
  localparam logic [1:0] LEN_32 = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DRAIN,
    ST_GAP,
    ST_FIN
  } state_t;

  // Number of serializer bits expected for a given length code.
  function automatic logic [5:0] shift_target(input logic [1:0] len);
    logic [5:0] t;
    case (len)
      LEN_8:   t = 6'd8;
      LEN_16:  t = 6'd16;
      LEN_24:  t = 6'd24;
      default: t = 6'd32;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/sti_desc_fifo.sv
// Four-entry descriptor FIFO with a combinational head and occupancy count.
module sti_desc_fifo
  import sti_cmd_sched_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DESC_W-1:0] push_data,
  input  logic              pop,
  output logic [DESC_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [DESC_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (cnt == CNT_W'(FIFO_DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Resetting the pointers is enough to discard whatever the array holds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/sti_cmd_sched.sv
// STI command scheduler: round-robin intake of two requesters into a FIFO and
// an issue FSM that feeds one descriptor at a time to the STI serializer.
module sti_cmd_sched
  import sti_cmd_sched_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              rq0_valid,
  output logic              rq0_ready,
  input  logic [DESC_W-1:0] rq0_desc,
  input  logic              rq1_valid,
  output logic              rq1_ready,
  input  logic [DESC_W-1:0] rq1_desc,
  output logic              load,
  output logic [DATA_W-1:0] pi_data,
  output logic [1:0]        pi_length,
  output logic              pi_fill,
  output logic              pi_msb,
  output logic              pi_low,
  output logic              pi_end,
  input  logic              so_valid,
  input  logic              oem_finish,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  fifo_cnt
);

  state_t            state, next_state;
  logic              rr_ptr, sealed, pi_end_q;
  logic              can_grant, grant0, grant1, push, fifo_pop;
  logic              fifo_full, fifo_empty;
  logic [DESC_W-1:0] push_data, fifo_head, issue_q;
  logic [5:0]        bit_cnt, target;
  logic [1:0]        gap_cnt;
  logic              gap_done, issue_last, shift_hit;

  // Readies come only from registered state plus inputs, never from a pop.
  assign can_grant = reset && !fifo_full && !sealed;
  assign grant0    = can_grant && rq0_valid && (!rq1_valid || !rr_ptr);
  assign grant1    = can_grant && rq1_valid && (!rq0_valid || rr_ptr);
  assign rq0_ready = grant0;
  assign rq1_ready = grant1;
  assign push      = grant0 || grant1;
  assign push_data = grant1 ? rq1_desc : rq0_desc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= 1'b0;
      sealed <= 1'b0;
    end else begin
      if (grant0)      rr_ptr <= 1'b1;
      else if (grant1) rr_ptr <= 1'b0;
      if (push && push_data[LAST_BIT]) sealed <= 1'b1;
    end
  end

  sti_desc_fifo u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .cnt       (fifo_cnt)
  );

  assign issue_last = issue_q[LAST_BIT];
  assign target     = shift_target(issue_q[LEN_LSB +: 2]);
  assign shift_hit  = so_valid && ((bit_cnt + 6'd1) == target);
  assign gap_done   = (gap_cnt == 2'(GAP_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (!fifo_empty) next_state = ST_LOAD;
      ST_LOAD:  next_state = ST_SHIFT;
      ST_SHIFT: if (shift_hit) next_state = ST_DRAIN;
      ST_DRAIN: if (!so_valid) next_state = ST_GAP;
      ST_GAP: begin
        if (gap_done) begin
          if (issue_last)       next_state = ST_FIN;
          else if (!fifo_empty) next_state = ST_LOAD;
          else                  next_state = ST_IDLE;
        end
      end
      ST_FIN:   next_state = ST_FIN;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    load     = 1'b0;
    busy     = 1'b1;
    fifo_pop = 1'b0;
    case (state)
      ST_IDLE: begin
        busy     = 1'b0;
        fifo_pop = !fifo_empty;
      end
      ST_LOAD: load = 1'b1;
      ST_GAP:  fifo_pop = gap_done && !issue_last && !fifo_empty;
      ST_FIN:  busy = !done;
      default: ;
    endcase
  end

  // A so_valid in DRAIN is a pulse beyond the target, so it flags err too.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issue_q  <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      pi_end_q <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (fifo_pop) issue_q <= fifo_head;
      if (load)                               bit_cnt <= '0;
      else if (state == ST_SHIFT && so_valid) bit_cnt <= bit_cnt + 6'd1;
      if (state == ST_GAP) gap_cnt <= gap_done ? 2'd0 : gap_cnt + 2'd1;
      else                 gap_cnt <= '0;
      if (load && issue_last) pi_end_q <= 1'b1;
      if (state == ST_FIN && oem_finish) done <= 1'b1;
      if (so_valid && (state inside {ST_IDLE, ST_LOAD, ST_GAP, ST_DRAIN})) err <= 1'b1;
    end
  end

  assign pi_data   = issue_q[DATA_W-1:0];
  assign pi_length = issue_q[LEN_LSB +: 2];
  assign pi_fill   = issue_q[FILL_BIT];
  assign pi_msb    = issue_q[MSB_BIT];
  assign pi_low    = issue_q[LOW_BIT];
  assign pi_end    = pi_end_q || (load && issue_last);

endmodule

// File: doc/sti_cmd_sched.md
STI_CMD_SCHED -- requirements
Module: sti_cmd_sched

Interface
REQ-001 SHALL have port clk, input, 1, the single rising-edge clock for all state.
REQ-002 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-003 SHALL have ports rq0_valid/rq1_valid, input, 1 each, requester descriptor offered.
REQ-004 SHALL have ports rq0_ready/rq1_ready, output, 1 each, descriptor accepted this cycle when valid&ready.
REQ-005 SHALL have ports rq0_desc/rq1_desc, input, 22 each: [15:0] data, [17:16] length, [18] fill, [19] msb, [20] low, [21] last.
REQ-006 SHALL have outputs load (1), pi_data (16), pi_length (2), pi_fill, pi_msb, pi_low, pi_end (1 each), driving the STI serializer.
REQ-007 SHALL have input so_valid (1), the serializer bit-valid strobe.
REQ-008 SHALL have input oem_finish (1), the converter memory-complete flag.
REQ-009 SHALL have outputs busy (1), done (1), err (1), and fifo_cnt (3), status.

Function
REQ-010 SHALL buffer accepted descriptors in a 4-entry FIFO; fifo_cnt = occupancy 0..4.
REQ-011 SHALL arbitrate round-robin: one grant per cycle, only when FIFO not full and not sealed; rr pointer flips to the other requester after each grant; on a tie the non-last-granted requester wins; after reset rq0 has priority.
REQ-012 SHALL derive rqN_ready combinationally from grant; ready never depends on a same-cycle pop (full FIFO blocks push even if popping).
REQ-013 SHALL set sealed when a descriptor with last=1 is accepted; while sealed both readies = 0.
REQ-014 SHALL run issue FSM IDLE -> LOAD -> SHIFT -> DRAIN -> GAP -> (LOAD | IDLE | FIN).
REQ-015 IDLE: on FIFO non-empty, pop head into the issue register, go to LOAD next cycle.
REQ-016 LOAD: load = 1 for exactly one cycle; pi_* fields = issue register; go to SHIFT.
REQ-017 pi_data/pi_length/pi_fill/pi_msb/pi_low SHALL hold stable from LOAD through GAP.
REQ-018 SHIFT: 6-bit bit counter increments per so_valid=1 cycle; target = 8/16/24/32 for length 00/01/10/11; counter reaching target goes to DRAIN.
REQ-019 DRAIN: wait for so_valid = 0, then go to GAP.
REQ-020 GAP: hold 3 cycles (serializer turnaround); then FIN if the issued descriptor had last=1, else LOAD when FIFO non-empty (pop in same cycle), else IDLE.
REQ-021 pi_end SHALL be 1 from the LOAD of a last=1 descriptor until reset.
REQ-022 FIN: wait for oem_finish = 1, then set done = 1, sticky until reset.
REQ-023 busy SHALL be 1 in any state other than IDLE and FIN-with-done.
REQ-024 err SHALL set (sticky) if so_valid = 1 in IDLE, LOAD or GAP, or if so_valid pulses exceed target; FSM continues unchanged.
REQ-025 Bit counter SHALL clear on every LOAD; no wrap beyond 32 occurs in legal operation.

Reset
REQ-026 On reset low, all outputs 0, fifo_cnt 0, FSM IDLE, rr pointer to rq0, sealed/done/err 0, immediately and asynchronously.
REQ-027 Reset mid-SHIFT SHALL discard FIFO and issue register; no load pulse for 1 cycle after release.

Structure
REQ-028 Shared package SHALL hold FSM state enum, descriptor field offsets, length codes, GAP_CYCLES = 3, FIFO_DEPTH = 4.
REQ-029 FIFO SHALL be a sub-module sti_desc_fifo (push/pop/full/empty/cnt); arbiter and FSM stay in the top.

Verification
REQ-030 Single desc rq0 {data 16'hA5C3, len 00, last 1} -> load pulse 1 cycle, 8 so_valid cycles, pi_end 1, FIN; oem_finish -> done = 1.
REQ-031 Both requesters valid 6 cycles continuously -> grants alternate rq0,rq1,rq0,rq1; fifo_cnt reaches 4, readies drop, no loss.
REQ-032 Four descs lengths 00,01,10,11 -> SHIFT lasts 8,16,24,32 so_valid cycles; fields stable per descriptor; 3-cycle GAP between loads.
REQ-033 so_valid = 1 during GAP -> err = 1 sticky, sequence completes normally.
REQ-034 last=1 accepted while rq1 still valid -> both readies 0 thereafter, rq1 never granted.
REQ-035 Reset low at bit 10 of a 16-bit shift -> all outputs 0 immediately; after release, fresh desc issues normally.
